// File: rtl/demux_1to8.sv
// demux_1to8: registered 1-to-8 demultiplexer.
//   One lane instance per output channel; each lane owns its data register,
//   its one-cycle valid flag and, optionally, its hit counter.
//   HOLD=0 : lanes not addressed this cycle load zero.
//   HOLD=1 : lanes not addressed this cycle keep their value.
//   Optional feature: define DEMUX_1TO8_HIT_CNT_EN to add cnt_clr / hit_cnt
//   (one 8-bit saturating transfer counter per channel).

module demux_1to8_lane #(
  parameter int WIDTH = 1,
  parameter bit HOLD  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             vld
`ifdef DEMUX_1TO8_HIT_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [7:0]       cnt
`endif
);

  // Data/valid register: load on hit, otherwise zero or hold by HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else begin
      vld <= hit;
      if (hit)
        q <= din;
      else if (!HOLD)
        q <= '0;
    end
  end

`ifdef DEMUX_1TO8_HIT_CNT_EN
  // Saturating hit counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= '0;
    else if (hit && (cnt != 8'hff))
      cnt <= cnt + 8'd1;
  end
`endif

endmodule

module demux_1to8 #(
  parameter int WIDTH = 1,
  parameter bit HOLD  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   din,
  input  logic [2:0]         sel,
  output logic [8*WIDTH-1:0] out,
  output logic [7:0]         out_valid
`ifdef DEMUX_1TO8_HIT_CNT_EN
  ,
  input  logic               cnt_clr,
  output logic [63:0]        hit_cnt
`endif
);

  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0]            hit;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_q;
`ifdef DEMUX_1TO8_HIT_CNT_EN
  logic [NUM_LANES-1:0][7:0]       lane_cnt;
`endif

  // One-hot lane strobe; all zero when no transfer this cycle.
  always_comb begin
    hit = '0;
    if (en)
      hit[sel] = 1'b1;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_1to8_lane #(
      .WIDTH (WIDTH),
      .HOLD  (HOLD)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .hit     (hit[k]),
      .din     (din),
      .q       (lane_q[k]),
      .vld     (out_valid[k])
`ifdef DEMUX_1TO8_HIT_CNT_EN
      ,
      .cnt_clr (cnt_clr),
      .cnt     (lane_cnt[k])
`endif
    );
  end

  // Channel k lands at out[k*WIDTH +: WIDTH], channel 0 at the LSBs.
  assign out = lane_q;
`ifdef DEMUX_1TO8_HIT_CNT_EN
  assign hit_cnt = lane_cnt;
`endif

endmodule

// File: tb/tb_demux_1to8.sv
// tb_demux_1to8: directed bench for demux_1to8.
//   u0: WIDTH=1 HOLD=0, u1: WIDTH=1 HOLD=1, u2: WIDTH=4 HOLD=0.
//   Counter checks are built only when DEMUX_1TO8_HIT_CNT_EN is defined.

module tb_demux_1to8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  sel;
  logic        din1;
  logic [3:0]  din4;
  logic [7:0]  out0, out1;
  logic [31:0] out2;
  logic [7:0]  vld0, vld1, vld2;
`ifdef DEMUX_1TO8_HIT_CNT_EN
  logic        cnt_clr;
  logic [63:0] cnt0, cnt1, cnt2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_1to8 #(.WIDTH(1), .HOLD(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din1), .sel(sel),
    .out(out0), .out_valid(vld0)
`ifdef DEMUX_1TO8_HIT_CNT_EN
    , .cnt_clr(cnt_clr), .hit_cnt(cnt0)
`endif
  );

  demux_1to8 #(.WIDTH(1), .HOLD(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din1), .sel(sel),
    .out(out1), .out_valid(vld1)
`ifdef DEMUX_1TO8_HIT_CNT_EN
    , .cnt_clr(cnt_clr), .hit_cnt(cnt1)
`endif
  );

  demux_1to8 #(.WIDTH(4), .HOLD(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din4), .sel(sel),
    .out(out2), .out_valid(vld2)
`ifdef DEMUX_1TO8_HIT_CNT_EN
    , .cnt_clr(cnt_clr), .hit_cnt(cnt2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic step(input logic e, input logic d1, input logic [3:0] d4, input logic [2:0] s);
    en = e; din1 = d1; din4 = d4; sel = s;
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse between edges, released just after an edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; sel = '0; din1 = 1'b0; din4 = '0;
`ifdef DEMUX_1TO8_HIT_CNT_EN
    cnt_clr = 1'b0;
`endif
    @(posedge clk);
    #1;

    // Async reset takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_out0", 64'(out0), 64'h00);
    check("rst_async_vld0", 64'(vld0), 64'h00);
    check("rst_async_out1", 64'(out1), 64'h00);
    check("rst_async_out2", 64'(out2), 64'h0);
    @(posedge clk);
    #1;
    check("rst_hold_vld0", 64'(vld0), 64'h00);
    rst_n = 1'b1;

    // Sweep sel 0..7 with back-to-back transfers.
    for (int s = 0; s < 8; s++) begin
      step(1'b1, 1'b1, 4'(s + 1), 3'(s));
      check($sformatf("sweep_out0_%0d", s), 64'(out0), 64'(8'h01 << s));
      check($sformatf("sweep_vld0_%0d", s), 64'(vld0), 64'(8'h01 << s));
      check($sformatf("sweep_out1_%0d", s), 64'(out1), 64'((9'h002 << s) - 9'h001));
      check($sformatf("sweep_out2_%0d", s), 64'(out2), 64'(32'(s + 1) << (4 * s)));
      check($sformatf("sweep_vld2_%0d", s), 64'(vld2), 64'(8'h01 << s));
    end

    // Idle cycle: HOLD=0 clears, HOLD=1 keeps, no valid.
    step(1'b0, 1'b1, 4'hf, 3'd4);
    check("idle_out0", 64'(out0), 64'h00);
    check("idle_vld0", 64'(vld0), 64'h00);
    check("idle_out1", 64'(out1), 64'hff);
    check("idle_vld1", 64'(vld1), 64'h00);
    check("idle_out2", 64'(out2), 64'h0);

    // Zero data still flags the channel.
    step(1'b1, 1'b0, 4'h0, 3'd0);
    check("zero_out0_s0", 64'(out0), 64'h00);
    check("zero_vld0_s0", 64'(vld0), 64'h01);
    check("zero_out1_s0", 64'(out1), 64'hfe);
    step(1'b1, 1'b0, 4'h0, 3'd5);
    check("zero_out0_s5", 64'(out0), 64'h00);
    check("zero_vld0_s5", 64'(vld0), 64'h20);
    check("zero_out1_s5", 64'(out1), 64'hde);

    // HOLD=1 accumulate then hold from a clean reset.
    en = 1'b0;
    pulse_reset();
    step(1'b1, 1'b1, 4'ha, 3'd2);
    check("hold_out1_a", 64'(out1), 64'h04);
    check("hold_vld1_a", 64'(vld1), 64'h04);
    check("hold_out2_a", 64'(out2), 64'h00000a00);
    step(1'b1, 1'b1, 4'h3, 3'd6);
    check("hold_out1_b", 64'(out1), 64'h44);
    check("hold_out0_b", 64'(out0), 64'h40);
    step(1'b0, 1'b1, 4'h3, 3'd6);
    check("hold_out1_c", 64'(out1), 64'h44);
    check("hold_vld1_c", 64'(vld1), 64'h00);

    // Independent transfers every cycle with changing data.
    step(1'b1, 1'b1, 4'h9, 3'd1);
    check("b2b_out2_0", 64'(out2), 64'h00000090);
    step(1'b1, 1'b0, 4'h6, 3'd7);
    check("b2b_out2_1", 64'(out2), 64'h60000000);
    check("b2b_vld0_1", 64'(vld0), 64'h80);
    check("b2b_out0_1", 64'(out0), 64'h00);
    step(1'b1, 1'b1, 4'h5, 3'd7);
    check("b2b_out0_2", 64'(out0), 64'h80);
    check("b2b_out1_2", 64'(out1), 64'hc6);

    // Reset during an in-flight transfer to channel 7.
    en = 1'b1; sel = 3'd7; din1 = 1'b1; din4 = 4'hc;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out0", 64'(out0), 64'h00);
    check("mid_rst_out1", 64'(out1), 64'h00);
    @(posedge clk);
    #1;
    check("mid_rst_edge_out0", 64'(out0), 64'h00);
    check("mid_rst_edge_vld0", 64'(vld0), 64'h00);
    check("mid_rst_edge_out2", 64'(out2), 64'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 4'hc, 3'd7);
    check("post_rst_out0", 64'(out0), 64'h80);
    check("post_rst_vld0", 64'(vld0), 64'h80);
    check("post_rst_out2", 64'(out2), 64'hc0000000);

`ifdef DEMUX_1TO8_HIT_CNT_EN
    en = 1'b0;
    pulse_reset();
    check("cnt_rst", cnt0, 64'h0);
    for (int i = 0; i < 255; i++) step(1'b1, 1'b1, 4'h1, 3'd3);
    check("cnt_255", cnt0, 64'h00000000ff000000);
    for (int i = 0; i < 45; i++) step(1'b1, 1'b1, 4'h1, 3'd3);
    check("cnt_sat", cnt0, 64'h00000000ff000000);
    step(1'b1, 1'b1, 4'h1, 3'd0);
    check("cnt_ch0", cnt1, 64'h00000000ff000001);
    cnt_clr = 1'b1;
    step(1'b1, 1'b1, 4'h1, 3'd3);
    cnt_clr = 1'b0;
    check("cnt_clr_wins", cnt2, 64'h0);
    step(1'b1, 1'b1, 4'h1, 3'd3);
    check("cnt_after_clr", cnt0, 64'h0000000001000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1to8.md
DEMUX_1TO8 -- requirements
Module: demux_1to8

Interface
REQ-001 Parameter WIDTH, default 1, bit width of the data input and of each of the 8 output channels.
REQ-002 Parameter HOLD, default 0: 0 = unselected channels drive zero; 1 = unselected channels retain their last value.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  input-valid qualifier; a transfer occurs only on cycles with en=1.
REQ-006 din  input  WIDTH  data to be routed.
REQ-007 sel  input  3  channel select, 0..7.
REQ-008 out  output  8*WIDTH  channel k occupies out[k*WIDTH +: WIDTH]; channel 0 is at the LSBs.
REQ-009 out_valid  output  8  one-hot flag, bit k set for one cycle when channel k received a transfer.

Function
REQ-010 The block SHALL register all outputs, with a latency of exactly one clock from sampled inputs to out/out_valid.
REQ-011 On a rising edge with en=1, channel sel SHALL load din, and out_valid SHALL become 1<<sel.
REQ-012 With en=1 and HOLD=0, every channel other than sel SHALL load zero.
REQ-013 With en=1 and HOLD=1, every channel other than sel SHALL keep its value.
REQ-014 With en=0, out_valid SHALL be 0.
REQ-015 With en=0 and HOLD=0, all channels SHALL load zero.
REQ-016 With en=0 and HOLD=1, all channels SHALL keep their values.
REQ-017 din=0 with en=1 SHALL still assert the out_valid bit of channel sel while its data is zero.
REQ-018 out_valid SHALL have at most one bit set in any cycle.
REQ-019 sel and din changing on every cycle SHALL be supported with no bubbles; each cycle is an independent transfer.
REQ-020 No combinational path SHALL exist from any input to any output.

Reset
REQ-021 While rst_n=0, out and out_valid SHALL be all-zero immediately, without waiting for a clock.
REQ-022 Reset asserted mid-operation SHALL discard any in-flight transfer.
REQ-023 After reset deassertion, the first rising edge SHALL perform a normal transfer per REQ-011 to REQ-016.
REQ-024 The hit counters (REQ-026) SHALL reset to zero.

Configuration
REQ-025 Macro DEMUX_1TO8_HIT_CNT_EN SHALL be the only compile-time option.
REQ-026 With DEMUX_1TO8_HIT_CNT_EN defined, the block SHALL add input cnt_clr (1 bit) and output hit_cnt (64 bits), with channel k's 8-bit counter at hit_cnt[8k +: 8].
REQ-027 A channel's counter SHALL increment on each transfer to that channel.
REQ-028 Each counter SHALL saturate at 255.
REQ-029 cnt_clr=1 SHALL zero all counters synchronously, and clear SHALL win over a simultaneous increment.
REQ-030 Without DEMUX_1TO8_HIT_CNT_EN, the ports cnt_clr and hit_cnt and all counter logic SHALL be absent; the remaining behaviour is identical.

Verification (WIDTH=1, HOLD=0 unless noted)
REQ-031 rst_n=0 applied between clock edges -> out=8'h00 and out_valid=8'h00 at once.
REQ-032 en=1, din=1, sel swept 0..7 on consecutive cycles -> one cycle later out=out_valid=1<<sel, i.e. 8'h01, 02, 04, 08, 10, 20, 40, 80.
REQ-033 en=1, din=0, sel=0, then sel=5 -> out=8'h00, with out_valid=8'h01 then 8'h20.
REQ-034 HOLD=1: din=1 sel=2, then din=1 sel=6, then en=0 -> out=8'h04, then 8'h44, then 8'h44 held with out_valid=8'h00.
REQ-035 Macro defined: 300 transfers to sel=3 -> hit_cnt[31:24]=255; then cnt_clr=1 together with a transfer to sel=3 -> counter=0.
REQ-036 Reset asserted while en=1 and sel=7 -> outputs stay zero, and the first transfer after release behaves per REQ-011.
